// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, entry record and helper for the hazard scoreboard.
//   REG_W / DEPTH : default register-number width and tracked pipeline depth
//   REG_*         : named architectural register numbers
//   sb_entry_t    : one in-flight destination record
//   fwd_sel_w()   : width of a forwarding select for a given depth
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W = 6;
    localparam int unsigned DEPTH = 3;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);
    localparam logic [REG_W-1:0] REG_V0   = REG_W'(2);
    localparam logic [REG_W-1:0] REG_A0   = REG_W'(4);
    localparam logic [REG_W-1:0] REG_RA   = REG_W'(31);
    localparam logic [REG_W-1:0] REG_HILO = REG_W'(33);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } sb_entry_t;

    // 0 selects the register file, k+1 selects entry k.
    function automatic int unsigned fwd_sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / hazard response bundle.
//   hold, id_valid, id_flush, id_rr1, id_rr2, id_wr, id_is_load : from the pipeline
//   stall, fwd_sel1, fwd_sel2, stall_cnt                         : from the scoreboard
// master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = hazard_scoreboard_pkg::DEPTH,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned SEL_W = fwd_sel_w(DEPTH);

    logic             hold;
    logic             id_valid;
    logic             id_flush;
    logic [REG_W-1:0] id_rr1;
    logic [REG_W-1:0] id_rr2;
    logic [REG_W-1:0] id_wr;
    logic             id_is_load;
    logic             stall;
    logic [SEL_W-1:0] fwd_sel1;
    logic [SEL_W-1:0] fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hold, id_valid, id_flush, id_rr1, id_rr2, id_wr, id_is_load,
        input  stall, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  hold, id_valid, id_flush, id_rr1, id_rr2, id_wr, id_is_load,
        output stall, fwd_sel1, fwd_sel2, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Per-read-port lookup: finds the youngest in-flight producer of rr.
//   entries  : scoreboard contents, entry 0 = EX (youngest)
//   rr       : source register number (0 = none)
//   fwd_sel  : 0 = register file, k+1 = forward from entry k
//   ready    : winning producer can supply data now (1 when no match)
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH      = hazard_scoreboard_pkg::DEPTH,
    parameter int unsigned LOAD_READY = 1,
    localparam int unsigned SEL_W     = fwd_sel_w(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [REG_W-1:0]      rr,
    output logic [SEL_W-1:0]      fwd_sel,
    output logic                  ready
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_sel = '0;
        ready   = 1'b1;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (entries[k].valid && (entries[k].dest == rr) && (rr != REG_ZERO)) begin
                fwd_sel = SEL_W'(k + 1);
                ready   = !entries[k].is_load || (k >= int'(LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker producing forwarding selects and load-use stalls.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   sb         : ID-stage request in, stall / fwd_sel1 / fwd_sel2 / stall_cnt out
// stall and fwd_sel* are combinational from the entries and the ID request.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH      = hazard_scoreboard_pkg::DEPTH,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned SEL_W     = fwd_sel_w(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave sb
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t [DEPTH-1:0] entries_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [SEL_W-1:0]      sel1;
    logic [SEL_W-1:0]      sel2;
    logic                  ready1;
    logic                  ready2;
    logic                  stall_c;
    logic                  issue_c;

    hazard_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY)) u_match1 (
        .entries (entries),
        .rr      (sb.id_rr1),
        .fwd_sel (sel1),
        .ready   (ready1)
    );

    hazard_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY)) u_match2 (
        .entries (entries),
        .rr      (sb.id_rr2),
        .fwd_sel (sel2),
        .ready   (ready2)
    );

    // A flushed instruction never stalls; it simply becomes a bubble.
    assign stall_c = sb.id_valid & ~sb.id_flush & (~ready1 | ~ready2);
    assign issue_c = sb.id_valid & ~sb.id_flush & ~stall_c & (sb.id_wr != REG_ZERO);

    assign sb.stall     = stall_c;
    assign sb.fwd_sel1  = sel1;
    assign sb.fwd_sel2  = sel2;
    assign sb.stall_cnt = cnt;

    // Shift the pipeline record; entry 0 gets the issuing instruction or a bubble.
    always_comb begin
        entries_nxt = entries;
        cnt_nxt     = cnt;
        if (!sb.hold) begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                entries_nxt[k] = entries[k-1];
            end
            entries_nxt[0] = '0;
            if (issue_c) begin
                entries_nxt[0] = '{valid: 1'b1, dest: sb.id_wr, is_load: sb.id_is_load};
            end
            if (stall_c && (cnt != '1)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
            cnt     <= '0;
        end else begin
            entries <= entries_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table on the default
// configuration plus hand-written multi-cycle sequences (hold, flush,
// mid-stream reset, LOAD_READY=2 and counter saturation with CNT_W=4).
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold = 1'b0;
    logic             id_valid = 1'b0;
    logic             id_flush = 1'b0;
    logic [REG_W-1:0] id_rr1 = '0;
    logic [REG_W-1:0] id_rr2 = '0;
    logic [REG_W-1:0] id_wr = '0;
    logic             id_is_load = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.DEPTH(3), .CNT_W(32)) ifa ();
    hazard_scoreboard_if #(.DEPTH(3), .CNT_W(4))  ifb ();

    assign ifa.hold = hold;       assign ifb.hold = hold;
    assign ifa.id_valid = id_valid;   assign ifb.id_valid = id_valid;
    assign ifa.id_flush = id_flush;   assign ifb.id_flush = id_flush;
    assign ifa.id_rr1 = id_rr1;     assign ifb.id_rr1 = id_rr1;
    assign ifa.id_rr2 = id_rr2;     assign ifb.id_rr2 = id_rr2;
    assign ifa.id_wr = id_wr;      assign ifb.id_wr = id_wr;
    assign ifa.id_is_load = id_is_load; assign ifb.id_is_load = id_is_load;

    hazard_scoreboard #(.DEPTH(3), .LOAD_READY(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .sb(ifa)
    );

    hazard_scoreboard #(.DEPTH(3), .LOAD_READY(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sb(ifb)
    );

    typedef struct {
        logic       valid;
        logic       flush;
        logic [5:0] rr1;
        logic [5:0] rr2;
        logic [5:0] wr;
        logic       ld;
        logic       stall;
        logic [1:0] sel1;
        logic [1:0] sel2;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic fl, input logic [5:0] r1,
                                input logic [5:0] r2, input logic [5:0] w, input logic ld,
                                input logic st, input logic [1:0] s1, input logic [1:0] s2);
        vec_t t;
        t.valid = v; t.flush = fl; t.rr1 = r1; t.rr2 = r2; t.wr = w; t.ld = ld;
        t.stall = st; t.sel1 = s1; t.sel2 = s2;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [5:0] r1,
                         input logic [5:0] r2, input logic [5:0] w, input logic ld);
        id_valid = v; id_flush = fl; id_rr1 = r1; id_rr2 = r2; id_wr = w; id_is_load = ld;
    endtask

    task automatic do_reset();
        hold = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    vec_t vecs [17];

    initial begin
        // Default configuration: E = entries after each edge, youngest first.
        vecs[0]  = mk(1, 0,  1,  2,  8, 0, 0, 0, 0);  // E=[8,-,-]
        vecs[1]  = mk(1, 0,  8,  0, 10, 0, 0, 1, 0);  // E=[10,8,-]
        vecs[2]  = mk(1, 0,  8, 10,  0, 0, 0, 2, 1);  // E=[-,10,8]
        vecs[3]  = mk(1, 0,  8, 10,  9, 1, 0, 3, 2);  // E=[9L,-,10]
        vecs[4]  = mk(1, 0,  0,  9, 11, 0, 1, 0, 1);  // load-use: bubble
        vecs[5]  = mk(1, 0,  0,  9, 11, 0, 0, 0, 2);  // E=[11,-,9L]
        vecs[6]  = mk(1, 0,  9, 11,  5, 0, 0, 3, 1);  // E=[5,11,-]
        vecs[7]  = mk(1, 0,  5,  0,  5, 0, 0, 1, 0);  // E=[5,5,11]
        vecs[8]  = mk(1, 0,  5, 11,  0, 0, 0, 1, 3);  // youngest of two 5s
        vecs[9]  = mk(1, 0,  5,  0, 33, 0, 0, 2, 0);  // E=[33,-,5]
        vecs[10] = mk(1, 0, 33,  5,  2, 0, 0, 1, 3);  // HI/LO forward
        vecs[11] = mk(1, 0,  2, 33,  4, 1, 0, 1, 2);  // E=[4L,2,33]
        vecs[12] = mk(0, 0,  4, 33,  7, 0, 0, 1, 3);  // invalid ID: no stall
        vecs[13] = mk(1, 0,  4,  2,  0, 0, 0, 2, 3);  // E=[-,-,4L]
        vecs[14] = mk(1, 0,  4,  0,  0, 0, 0, 3, 0);  // load in WB ready
        vecs[15] = mk(1, 0,  4,  0,  0, 0, 0, 0, 0);  // fell off the end
        vecs[16] = mk(1, 0,  0,  0,  0, 0, 0, 0, 0);  // zero register

        do_reset();
        @(negedge clk);
        check("rst_stall", 32'(ifa.stall), 32'd0);
        check("rst_sel1", 32'(ifa.fwd_sel1), 32'd0);
        check("rst_cnt", ifa.stall_cnt, 32'd0);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].flush, vecs[i].rr1, vecs[i].rr2, vecs[i].wr, vecs[i].ld);
            @(negedge clk);
            check($sformatf("v%0d_stall", i), 32'(ifa.stall), 32'(vecs[i].stall));
            check($sformatf("v%0d_sel1", i), 32'(ifa.fwd_sel1), 32'(vecs[i].sel1));
            check($sformatf("v%0d_sel2", i), 32'(ifa.fwd_sel2), 32'(vecs[i].sel2));
            tick();
        end
        check("table_cnt", ifa.stall_cnt, 32'd1);

        // Hold during a load-use: state and counter frozen, stall stays up.
        do_reset();
        drive(1, 0, 0, 0, 9, 1);
        tick();
        drive(1, 0, 0, 9, 12, 0);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_stall", i), 32'(ifa.stall), 32'd1);
            check($sformatf("hold%0d_sel2", i), 32'(ifa.fwd_sel2), 32'd1);
            check($sformatf("hold%0d_cnt", i), ifa.stall_cnt, 32'd0);
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        check("unhold_stall", 32'(ifa.stall), 32'd1);
        tick();
        @(negedge clk);
        check("after_stall", 32'(ifa.stall), 32'd0);
        check("after_sel2", 32'(ifa.fwd_sel2), 32'd2);
        check("after_cnt", ifa.stall_cnt, 32'd1);
        tick();
        drive(1, 0, 12, 0, 14, 0);
        @(negedge clk);
        check("consumer_sel1", 32'(ifa.fwd_sel1), 32'd1);
        tick();
        drive(1, 0, 0, 0, 15, 0);
        tick();

        // Mid-stream reset with E=[15,14,12].
        drive(1, 0, 15, 12, 0, 0);
        @(negedge clk);
        check("pre_rst_sel1", 32'(ifa.fwd_sel1), 32'd1);
        check("pre_rst_sel2", 32'(ifa.fwd_sel2), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(ifa.stall), 32'd0);
        check("mid_rst_sel1", 32'(ifa.fwd_sel1), 32'd0);
        check("mid_rst_sel2", 32'(ifa.fwd_sel2), 32'd0);
        check("mid_rst_cnt", ifa.stall_cnt, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 0, 15, 12, 0, 0);
        @(negedge clk);
        check("post_rst_sel1", 32'(ifa.fwd_sel1), 32'd0);
        check("post_rst_sel2", 32'(ifa.fwd_sel2), 32'd0);
        tick();

        // Flush during a hazard: no stall, bubble enters, id_wr not recorded.
        do_reset();
        drive(1, 0, 0, 0, 9, 1);
        tick();
        drive(1, 1, 9, 0, 13, 0);
        @(negedge clk);
        check("flush_stall", 32'(ifa.stall), 32'd0);
        check("flush_sel1", 32'(ifa.fwd_sel1), 32'd1);
        tick();
        drive(1, 0, 13, 9, 0, 0);
        @(negedge clk);
        check("flushed_sel1", 32'(ifa.fwd_sel1), 32'd0);
        check("flushed_sel2", 32'(ifa.fwd_sel2), 32'd2);
        check("flushed_stall", 32'(ifa.stall), 32'd0);
        check("flushed_cnt", ifa.stall_cnt, 32'd0);
        tick();

        // LOAD_READY=2: two stall cycles before forwarding from WB.
        do_reset();
        drive(1, 0, 0, 0, 9, 1);
        tick();
        drive(1, 0, 0, 9, 11, 0);
        @(negedge clk);
        check("lr2_c0_stall", 32'(ifb.stall), 32'd1);
        check("lr2_c0_sel2", 32'(ifb.fwd_sel2), 32'd1);
        tick();
        @(negedge clk);
        check("lr2_c1_stall", 32'(ifb.stall), 32'd1);
        check("lr2_c1_sel2", 32'(ifb.fwd_sel2), 32'd2);
        check("lr2_c1_cnt", 32'(ifb.stall_cnt), 32'd1);
        tick();
        @(negedge clk);
        check("lr2_c2_stall", 32'(ifb.stall), 32'd0);
        check("lr2_c2_sel2", 32'(ifb.fwd_sel2), 32'd3);
        check("lr2_c2_cnt", 32'(ifb.stall_cnt), 32'd2);
        tick();

        // Saturation: LW r9,(r9) repeated gives 2 stalls per 3 cycles on dut_b.
        do_reset();
        drive(1, 0, 9, 0, 9, 1);
        tick();
        for (int i = 0; i < 21; i++) tick();
        @(negedge clk);
        check("sat_mid_cnt", 32'(ifb.stall_cnt), 32'd14);
        tick();
        for (int i = 0; i < 9; i++) tick();
        @(negedge clk);
        check("sat_cnt", 32'(ifb.stall_cnt), 32'd15);
        tick();
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check("sat_hold_cnt", 32'(ifb.stall_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Tracks the destination registers of instructions in flight, given the register numbers produced by the ID-stage read/write register decoder. Each cycle it compares the ID-stage source registers against pending writes and produces a forwarding select per read port. When the youngest matching producer cannot supply its data yet (a load before its ready stage), it raises a load-use stall and inserts a bubble. It generalises the fixed 6-bit register numbering to a parametrised address width and pipeline depth, and adds a saturating stall performance counter.

Parameters:
REG_W, 6, width of register numbers; 0 is the hardwired zero register and is never a hazard; 33 is the HI/LO pseudo-register.
DEPTH, 3, number of tracked in-flight stages. Entry 0 is EX and entry DEPTH-1 is WB.
LOAD_READY, 1, lowest entry index at which a load result is available for forwarding (1 = MEM output).
CNT_W, 32, width of the stall counter.

Ports:
clk  in  1  pipeline clock.
rst_n  in  1  asynchronous reset, active low.
hold  in  1  global pipeline freeze (for example, memory busy); the scoreboard state does not advance.
id_valid  in  1  the ID stage holds a real instruction.
id_flush  in  1  the ID instruction is being killed (branch/exception); it is not entered into the scoreboard.
id_rr1  in  REG_W  source register 1 (0 = none).
id_rr2  in  REG_W  source register 2 (0 = none).
id_wr  in  REG_W  destination register (0 = none).
id_is_load  in  1  the ID instruction is a load (LB/LH/LBU/LHU/LW).
stall  out  1  load-use hazard; ID and IF must hold.
fwd_sel1  out  $clog2(DEPTH+1)  0 = register file; k+1 = forward from entry k.
fwd_sel2  out  $clog2(DEPTH+1)  same encoding, for port 2.
stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries of {valid, dest[REG_W], is_load}. No other state except stall_cnt.
- Reset (asynchronous, rst_n=0): all entries become invalid and stall_cnt=0. Consequently stall=0 and fwd_sel1=fwd_sel2=0. A reset in mid-stream discards all pending entries immediately.
- Match for port p at entry k: entry[k].valid, and entry[k].dest equals id_rrp, and id_rrp is not 0.
- Priority: the youngest match (lowest k) wins. fwd_selp = k+1; with no match, fwd_selp = 0.
- Ready rule: the winning entry is ready if !is_load or k >= LOAD_READY.
- stall = id_valid & !id_flush & (the winner on either port is not ready). stall is combinational with 0 cycles of latency.
- While stall=1, fwd_sel outputs still show the winning entry. The consumer ignores them because ID is held.
- Update on the clock edge when hold=0:
  - entry[k] takes entry[k-1] for k=1..DEPTH-1.
  - entry[0] is loaded with {1, id_wr, id_is_load} if id_valid & !id_flush & !stall & id_wr!=0. Otherwise entry[0] becomes invalid, which is the bubble.
- The oldest entry falls off the end. Its result is written to the register file during that WB cycle, so a same-cycle ID read is covered by forwarding from entry DEPTH-1.
- hold=1: all entries and stall_cnt are frozen. The outputs are still evaluated combinationally from the frozen state. hold takes priority over id_flush and stall.
- stall_cnt increments by 1 in each cycle where stall=1 & hold=0. It saturates at 2^CNT_W-1 and never wraps.
- id_flush together with a hazard: stall=0 and a bubble is inserted.
- A write to register 0 is never recorded. Multiple in-flight entries with the same dest are legal; the youngest one wins.

Decomposition:
- Shared package: REG_W, DEPTH, and the named register constants REG_ZERO=0, REG_V0=2, REG_A0=4, REG_RA=31, REG_HILO=33. It also holds the sb_entry_t struct {valid, dest, is_load} and the fwd_sel width function.
- One sub-module, hazard_match. It is purely combinational and is instantiated once per read port. It takes the entry array and one source register, and returns {fwd_sel, ready}.

Test Plan:
- Reset: pulse rst_n=0 mid-stream with 3 valid entries -> immediately stall=0, fwd_sel=0, stall_cnt=0; after release, a read of the former dests gives fwd=0.
- ALU back-to-back: cycle 0 issue ADDU wr=8; cycle 1 issue rr1=8 -> fwd_sel1=1, stall=0.
- Load-use: LW wr=9, then rr2=9 -> stall=1 for exactly 1 cycle, then fwd_sel2=2, stall=0, stall_cnt=1. Repeat with LOAD_READY=2 -> 2 stall cycles.
- Priority and zero register: entries dest 5 at k=2 and k=0 -> fwd_sel1=1. A source rr1=0 against an entry with dest 0 -> fwd 0. HI/LO: MULTU wr=33, then MFLO rr1=33 -> fwd_sel1=1.
- Hold and flush: hold=1 for 4 cycles during a load-use -> entries frozen, stall held at 1, stall_cnt unchanged. Flush during a hazard -> stall=0, a bubble enters, and the flushed id_wr is not recorded.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt stays at 15.
